// File: rtl/reg_operand_fetch_pkg.sv
// Shared definitions for the register operand fetch unit.
// Holds the register bank geometry, the default tag and buffer sizes, and the
// forwarding helper used when the FETCH_BYPASS_EN build option is enabled.
package reg_operand_fetch_pkg;

    localparam int REG_ADDR_W         = 5;
    localparam int REG_DATA_W         = 32;
    localparam int TAG_W_DEFAULT      = 4;
    localparam int FIFO_DEPTH_DEFAULT = 2;

    typedef logic [REG_ADDR_W-1:0] regAddrT;
    typedef logic [REG_DATA_W-1:0] regDataT;

    // Picks the writeback value over the bank value when the bank is being
    // written at the very address that was read on the previous edge.
    function automatic regDataT bypassSelect(
        input logic    wbWr,
        input regAddrT wbDir,
        input regAddrT srcDir,
        input regDataT wbData,
        input regDataT bankData
    );
        if (wbWr && (wbDir == srcDir)) begin
            return wbData;
        end
        return bankData;
    endfunction

endpackage

// File: rtl/reg_operand_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO for operand pairs {tag, op_b, op_a}.
// The head entry is held in its own register so the consumer sees flop
// outputs; the head register is refreshed whenever the oldest entry changes.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_pushData,
    input  logic                         i_pop,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_nextCount;
    logic [PTR_W-1:0] w_nextRdPtr;
    logic [WIDTH-1:0] w_nextHead;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // Pops on an empty FIFO are ignored; a push into a full FIFO only lands
    // when the same cycle frees a slot. Flush cancels both.
    assign w_pop  = i_pop & ~w_empty & ~flush;
    assign w_push = i_push & ~flush & (~w_full | w_pop);

    assign w_nextCount = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_nextRdPtr = w_pop ? (r_rdPtr + PTR_W'(1)) : r_rdPtr;

    // The new head is whichever entry sits at the next read pointer; when
    // that slot is being written this cycle the incoming data is forwarded.
    always_comb begin
        w_nextHead = r_head;
        if (w_nextCount != '0) begin
            if (w_push && (r_wrPtr == w_nextRdPtr)) begin
                w_nextHead = i_pushData;
            end else begin
                w_nextHead = r_mem[w_nextRdPtr];
            end
        end
    end

    // Storage array; no reset needed because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers, occupancy and head register; reset and flush empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_rdPtr <= w_nextRdPtr;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            r_count <= w_nextCount;
            r_head  <= w_nextHead;
        end
    end

    assign o_valid = ~w_empty;
    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: read-side initiator for the 32x32 register bank.
// Accepts operand requests, issues bank reads, captures doa/dob one cycle
// later and buffers the pairs for the execute stage. Requests are only
// accepted when buffer space is guaranteed (credit = FIFO_DEPTH).
// Build option FETCH_BYPASS_EN: forward a same-cycle writeback into the
// captured operands when it targets the address that was just read.
module reg_operand_fetch
    import reg_operand_fetch_pkg::*;
#(
    parameter int TAG_W      = TAG_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_ADDR_W-1:0] req_dir_a,
    input  logic [REG_ADDR_W-1:0] req_dir_b,
    input  logic [TAG_W-1:0]      req_tag,
    output logic [REG_ADDR_W-1:0] dir_a,
    output logic [REG_ADDR_W-1:0] dir_b,
    output logic                  reg_rd,
    input  logic [REG_DATA_W-1:0] doa,
    input  logic [REG_DATA_W-1:0] dob,
    input  logic                  wb_wr,
    input  logic [REG_ADDR_W-1:0] wb_dir,
    input  logic [REG_DATA_W-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [REG_DATA_W-1:0] op_a,
    output logic [REG_DATA_W-1:0] op_b,
    output logic [TAG_W-1:0]      op_tag
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = TAG_W + 2*REG_DATA_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    logic               r_inflight;
    logic [TAG_W-1:0]   r_tag;

    logic               w_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_fifoValid;
    logic [CNT_W-1:0]   w_fifoCount;
    logic [OCC_W-1:0]   w_occupancy;
    regDataT            w_opA;
    regDataT            w_opB;
    logic [ENTRY_W-1:0] w_pushData;
    logic [ENTRY_W-1:0] w_head;

    // Credit check: buffered entries plus the pending capture, less any pair
    // leaving this cycle, must leave room for one more.
    assign w_pop       = w_fifoValid & op_ready;
    assign w_occupancy = {1'b0, w_fifoCount} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign req_ready   = ~rst & ~flush & (w_occupancy < DEPTH_OCC);
    assign w_fire      = req_valid & req_ready;

    assign reg_rd = w_fire;
    assign dir_a  = w_fire ? req_dir_a : '0;
    assign dir_b  = w_fire ? req_dir_b : '0;

`ifdef FETCH_BYPASS_EN
    regAddrT r_dirA;
    regAddrT r_dirB;

    // Remember the read addresses so a writeback landing in the capture
    // cycle can be matched against them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirA <= '0;
            r_dirB <= '0;
        end else if (w_fire) begin
            r_dirA <= req_dir_a;
            r_dirB <= req_dir_b;
        end
    end

    assign w_opA = bypassSelect(wb_wr, wb_dir, r_dirA, wb_data, doa);
    assign w_opB = bypassSelect(wb_wr, wb_dir, r_dirB, wb_data, dob);
`else
    logic w_unusedWb;

    assign w_unusedWb = ^{wb_wr, wb_dir, wb_data};
    assign w_opA      = doa;
    assign w_opB      = dob;
`endif

    // In-flight flag and tag track the read issued last cycle; reset and
    // flush discard it so its data is never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else if (flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fire;
            if (w_fire) begin
                r_tag <= req_tag;
            end
        end
    end

    assign w_push     = r_inflight & ~flush;
    assign w_pushData = {r_tag, w_opB, w_opA};

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetchFifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_valid    (w_fifoValid),
        .o_count    (w_fifoCount),
        .o_head     (w_head)
    );

    assign op_valid = w_fifoValid;
    assign op_a     = w_head[REG_DATA_W-1:0];
    assign op_b     = w_head[2*REG_DATA_W-1:REG_DATA_W];
    assign op_tag   = w_head[ENTRY_W-1:2*REG_DATA_W];

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Testbench for reg_operand_fetch with a behavioural 32x32 register bank.
// Bank reset contents: entry i holds i, except entry 1 = 11 and entry 5 = 0xDDDD.
// Expected op_a in the writeback test depends on FETCH_BYPASS_EN.
module tb_reg_operand_fetch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_dir_a;
    logic [4:0]  req_dir_b;
    logic [3:0]  req_tag;
    logic [4:0]  dir_a;
    logic [4:0]  dir_b;
    logic        reg_rd;
    logic [31:0] doa;
    logic [31:0] dob;
    logic        wb_wr;
    logic [4:0]  wb_dir;
    logic [31:0] wb_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_tag;

    logic        cRst;
    logic        cFlush;
    logic        cWbWr;
    logic [4:0]  cWbDir;
    logic [31:0] cWbData;

    logic [31:0] bankMem [32];

    int testsRun;
    int testsFailed;
    int accepted;

    reg_operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir_a (req_dir_a),
        .req_dir_b (req_dir_b),
        .req_tag   (req_tag),
        .dir_a     (dir_a),
        .dir_b     (dir_b),
        .reg_rd    (reg_rd),
        .doa       (doa),
        .dob       (dob),
        .wb_wr     (wb_wr),
        .wb_dir    (wb_dir),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_tag    (op_tag)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank model: synchronous read on reg_rd, write on wb_wr
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                bankMem[i] <= 32'(i);
            end
            bankMem[1] <= 32'd11;
            bankMem[5] <= 32'hDDDD;
            doa        <= '0;
            dob        <= '0;
        end else begin
            if (reg_rd) begin
                doa <= bankMem[dir_a];
                dob <= bankMem[dir_b];
            end
            if (wb_wr) begin
                bankMem[wb_dir] <= wb_data;
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, return at the falling edge
    task automatic applyStimulus(input logic valid, input logic [4:0] da,
                                 input logic [4:0] db, input logic [3:0] tag,
                                 input logic opRdy);
        @(posedge clk);
        #1;
        rst       = cRst;
        flush     = cFlush;
        wb_wr     = cWbWr;
        wb_dir    = cWbDir;
        wb_data   = cWbData;
        req_valid = valid;
        req_dir_a = da;
        req_dir_b = db;
        req_tag   = tag;
        op_ready  = opRdy;
        @(negedge clk);
    endtask

    // Single comparison point for every check in this bench
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_dir_a = '0; req_dir_b = '0;
        req_tag = '0; wb_wr = 1'b0; wb_dir = '0; wb_data = '0; op_ready = 1'b0;
        cRst = 1'b1; cFlush = 1'b0; cWbWr = 1'b0; cWbDir = '0; cWbData = '0;

        // Reset with a request offered: nothing may be accepted or issued
        applyStimulus(1'b1, 5'd3, 5'd4, 4'd1, 1'b0);
        applyStimulus(1'b1, 5'd3, 5'd4, 4'd1, 1'b0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_reg_rd",    32'(reg_rd),    32'd0);
        checkOutput("rst_dir_a",     32'(dir_a),     32'd0);
        checkOutput("rst_op_valid",  32'(op_valid),  32'd0);
        checkOutput("rst_op_a",      op_a,           32'd0);
        checkOutput("rst_op_tag",    32'(op_tag),    32'd0);
        cRst = 1'b0;

        // Basic fetch: issue in T, pair visible in T+2
        applyStimulus(1'b1, 5'd1, 5'd5, 4'd3, 1'b0);
        checkOutput("basic_req_ready", 32'(req_ready), 32'd1);
        checkOutput("basic_reg_rd",    32'(reg_rd),    32'd1);
        checkOutput("basic_dir_a",     32'(dir_a),     32'd1);
        checkOutput("basic_dir_b",     32'(dir_b),     32'd5);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("basic_idle_rd",   32'(reg_rd),    32'd0);
        checkOutput("basic_t1_valid",  32'(op_valid),  32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("basic_t2_valid",  32'(op_valid),  32'd1);
        checkOutput("basic_op_a",      op_a,           32'd11);
        checkOutput("basic_op_b",      op_b,           32'hDDDD);
        checkOutput("basic_op_tag",    32'(op_tag),    32'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("basic_hold_a",    op_a,           32'd11);
        checkOutput("basic_hold_tag",  32'(op_tag),    32'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("basic_drained",   32'(op_valid),  32'd0);

        // Back-pressure: four offers with op_ready low, only two fit
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(accepted), 5'(accepted + 8), 4'(accepted), 1'b0);
            checkOutput("stall_ready", 32'(req_ready), (i < 2) ? 32'd1 : 32'd0);
            if (req_ready) accepted++;
        end
        checkOutput("stall_accepted", 32'(accepted), 32'd2);
        applyStimulus(1'b1, 5'd2, 5'd10, 4'd2, 1'b1);
        checkOutput("drain_head0_tag", 32'(op_tag),   32'd0);
        checkOutput("drain_resume",    32'(req_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("drain_head1_tag", 32'(op_tag),   32'd1);
        checkOutput("drain_head1_b",   op_b,           32'd9);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("drain_head2_val", 32'(op_valid), 32'd1);
        checkOutput("drain_head2_tag", 32'(op_tag),   32'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("drain_empty",     32'(op_valid), 32'd0);

        // Streaming: eight requests with op_ready high, one pair per cycle
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i < 8, 5'(i + 16), 5'(i + 24), 4'(i), 1'b1);
            if (i < 8) checkOutput("stream_ready", 32'(req_ready), 32'd1);
            checkOutput("stream_valid", 32'(op_valid), (i >= 2 && i < 10) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 10) begin
                checkOutput("stream_tag", 32'(op_tag), 32'(i - 2));
                checkOutput("stream_a",   op_a,        32'(i - 2 + 16));
            end
        end

        // Writeback landing in the capture cycle
        applyStimulus(1'b1, 5'd4, 5'd6, 4'd9, 1'b0);
        cWbWr = 1'b1; cWbDir = 5'd4; cWbData = 32'h1234;
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        cWbWr = 1'b0; cWbDir = '0; cWbData = '0;
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("wb_valid", 32'(op_valid), 32'd1);
`ifdef FETCH_BYPASS_EN
        checkOutput("wb_op_a", op_a, 32'h1234);
`else
        checkOutput("wb_op_a", op_a, 32'd4);
`endif
        checkOutput("wb_op_b",   op_b,         32'd6);
        checkOutput("wb_op_tag", 32'(op_tag),  32'd9);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("wb_drained", 32'(op_valid), 32'd0);

        // Flush with one buffered + one in flight (k=0), then with a full buffer (k=1)
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 5'd1, 5'd2, 4'd5, 1'b0);
            applyStimulus(1'b1, 5'd3, 5'd5, 4'd6, 1'b0);
            if (k == 1) applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
            cFlush = 1'b1;
            applyStimulus(1'b1, 5'd7, 5'd8, 4'd7, 1'b0);
            checkOutput("flush_ready_low", 32'(req_ready), 32'd0);
            checkOutput("flush_no_issue",  32'(reg_rd),    32'd0);
            cFlush = 1'b0;
            applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b0);
            checkOutput("flush_valid",     32'(op_valid),  32'd0);
            checkOutput("flush_ready",     32'(req_ready), 32'd1);
            for (int j = 0; j < 3; j++) begin
                applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
                checkOutput("flush_no_stale", 32'(op_valid), 32'd0);
            end
        end

        // Reset in the middle of a stream discards everything
        applyStimulus(1'b1, 5'd1, 5'd5, 4'd1, 1'b1);
        applyStimulus(1'b1, 5'd2, 5'd6, 4'd2, 1'b1);
        applyStimulus(1'b1, 5'd3, 5'd7, 4'd3, 1'b1);
        checkOutput("mid_valid_before", 32'(op_valid), 32'd1);
        cRst = 1'b1;
        applyStimulus(1'b1, 5'd4, 5'd8, 4'd4, 1'b1);
        checkOutput("mid_rst_ready",  32'(req_ready), 32'd0);
        checkOutput("mid_rst_rd",     32'(reg_rd),    32'd0);
        applyStimulus(1'b1, 5'd4, 5'd8, 4'd4, 1'b1);
        checkOutput("mid_rst_valid",  32'(op_valid),  32'd0);
        checkOutput("mid_rst_op_a",   op_a,           32'd0);
        checkOutput("mid_rst_ready2", 32'(req_ready), 32'd0);
        cRst = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("mid_after_ready", 32'(req_ready), 32'd1);
        checkOutput("mid_after_valid", 32'(op_valid),  32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 4'd0, 1'b1);
        checkOutput("mid_no_stale",    32'(op_valid),  32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
